// File: rtl/upc_checkout_ctrl.sv
// UPC checkout lane controller: scan intake, session tallies, exit gate / alarm decision.
// Optional idle-session abandonment is enabled with `define UPC_SESSION_TIMEOUT_EN.
module upc_checkout_ctrl #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_valid,
    output logic             scan_ready,
    input  logic [3:0]       scan_code,
    input  logic             exit_req,
    input  logic             alarm_ack,
    output logic             gate_open,
    output logic             alarm,
    output logic             code_err,
    output logic [3:0]       disp_code,
    output logic             disp_valid,
    output logic [CNT_W-1:0] item_cnt,
    output logic [CNT_W-1:0] sale_cnt,
    output logic [CNT_W-1:0] stolen_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SESSION,
        RELEASE,
        ALARM
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t next_state;

    logic       accept;
    logic       code_ok;
    logic       item_sale;
    logic       item_stolen;
    logic       take;
    logic       stolen_any;
    logic       clear_tally;
    logic       timeout_hit;
    logic [2:0] upc;

    // scan_code is {M,U,P,C}
    assign upc         = scan_code[2:0];
    assign accept      = scan_valid & scan_ready;
    assign code_ok     = (upc != 3'd2) && (upc != 3'd7);
    assign item_sale   = (scan_code[2] & scan_code[0]) | scan_code[1];
    assign item_stolen = ~scan_code[1] & ~scan_code[3] & (scan_code[2] | ~scan_code[0]);
    assign take        = accept & code_ok;
    // Exit decision must see the stolen bit of an item scanned in the same cycle.
    assign stolen_any  = (stolen_cnt != '0) | (take & item_stolen);
    assign clear_tally = (state == RELEASE) | ((state == ALARM) & alarm_ack) | timeout_hit;

`ifdef UPC_SESSION_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (state == SESSION) && !accept && !exit_req &&
                         (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if ((state != SESSION) || accept || exit_req || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // NOTE: next_state gets a default first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (exit_req && take)  next_state = stolen_any ? ALARM : RELEASE;
                else if (take)         next_state = SESSION;
            end
            SESSION: begin
                if (exit_req)          next_state = stolen_any ? ALARM : RELEASE;
                else if (timeout_hit)  next_state = IDLE;
            end
            RELEASE:                   next_state = IDLE;
            ALARM: begin
                if (alarm_ack)         next_state = IDLE;
            end
            default:                   next_state = IDLE;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scan_ready <= 1'b1;
            gate_open  <= 1'b0;
            alarm      <= 1'b0;
            code_err   <= 1'b0;
            disp_code  <= '0;
            disp_valid <= 1'b0;
            item_cnt   <= '0;
            sale_cnt   <= '0;
            stolen_cnt <= '0;
        end else begin
            state      <= next_state;
            scan_ready <= (next_state == IDLE) || (next_state == SESSION);
            gate_open  <= (state == RELEASE) || ((state == IDLE) && exit_req && !take);
            alarm      <= (state == ALARM) && !alarm_ack;
            code_err   <= accept && !code_ok;

            if (clear_tally) begin
                item_cnt   <= '0;
                sale_cnt   <= '0;
                stolen_cnt <= '0;
                disp_valid <= 1'b0;
            end else if (take) begin
                disp_code  <= scan_code;
                disp_valid <= 1'b1;
                if (item_cnt != CNT_MAX)                  item_cnt   <= item_cnt + 1'b1;
                if (item_sale && (sale_cnt != CNT_MAX))   sale_cnt   <= sale_cnt + 1'b1;
                if (item_stolen && (stolen_cnt != CNT_MAX)) stolen_cnt <= stolen_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Self-checking bench for upc_checkout_ctrl: directed checkout scenarios plus random
// sessions compared against a tally-level reference model.
module tb_upc_checkout_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             scan_valid;
    logic             scan_ready;
    logic [3:0]       scan_code;
    logic             exit_req;
    logic             alarm_ack;
    logic             gate_open;
    logic             alarm;
    logic             code_err;
    logic [3:0]       disp_code;
    logic             disp_valid;
    logic [CNT_W-1:0] item_cnt;
    logic [CNT_W-1:0] sale_cnt;
    logic [CNT_W-1:0] stolen_cnt;

    upc_checkout_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .exit_req   (exit_req),
        .alarm_ack  (alarm_ack),
        .gate_open  (gate_open),
        .alarm      (alarm),
        .code_err   (code_err),
        .disp_code  (disp_code),
        .disp_valid (disp_valid),
        .item_cnt   (item_cnt),
        .sale_cnt   (sale_cnt),
        .stolen_cnt (stolen_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: session tallies as plain integers.
    int       m_items;
    int       m_sale;
    int       m_stolen;
    logic [3:0] m_disp;
    bit       m_dvalid;
    bit       m_alarmed;

    function automatic bit code_valid(input logic [3:0] c);
        int v;
        v = c[2] * 4 + c[1] * 2 + c[0];
        return !(v == 2 || v == 7);
    endfunction

    function automatic int is_sale(input logic [3:0] c);
        int u, p, cc;
        u = c[2]; p = c[1]; cc = c[0];
        return (u * cc + p) > 0 ? 1 : 0;
    endfunction

    function automatic int is_stolen(input logic [3:0] c);
        int m, u, p, cc;
        m = c[3]; u = c[2]; p = c[1]; cc = c[0];
        return (p == 0 && m == 0 && (u == 1 || cc == 0)) ? 1 : 0;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        m_items   = 0;
        m_sale    = 0;
        m_stolen  = 0;
        m_dvalid  = 0;
        m_alarmed = 0;
    endtask

    task automatic check_tallies(input string tag);
        check({tag, ".item_cnt"},   32'(item_cnt),   32'(m_items));
        check({tag, ".sale_cnt"},   32'(sale_cnt),   32'(m_sale));
        check({tag, ".stolen_cnt"}, 32'(stolen_cnt), 32'(m_stolen));
        check({tag, ".disp_valid"}, 32'(disp_valid), 32'(m_dvalid));
        check({tag, ".disp_code"},  32'(disp_code),  32'(m_disp));
    endtask

    // One cycle of optional scan and optional exit, then follow the exit outcome.
    task automatic step(input bit sv, input logic [3:0] code, input bit ex, input string tag);
        scan_valid = sv;
        scan_code  = code;
        exit_req   = ex;
        tick;
        scan_valid = 1'b0;
        exit_req   = 1'b0;
        if (sv && code_valid(code)) begin
            m_items  = sat(m_items + 1);
            m_sale   = sat(m_sale + is_sale(code));
            m_stolen = sat(m_stolen + is_stolen(code));
            m_disp   = code;
            m_dvalid = 1;
        end
        check({tag, ".code_err"}, 32'(code_err), 32'(sv && !code_valid(code)));
        if (!ex) begin
            check({tag, ".gate_idle"}, 32'(gate_open), 0);
            check_tallies(tag);
        end else if (m_items == 0) begin
            check({tag, ".gate_direct"}, 32'(gate_open), 1);
            check({tag, ".alarm_direct"}, 32'(alarm), 0);
            check_tallies(tag);
            tick;
            check({tag, ".gate_pulse_end"}, 32'(gate_open), 0);
        end else if (m_stolen == 0) begin
            check({tag, ".gate_early"}, 32'(gate_open), 0);
            check_tallies({tag, ".pre_release"});
            tick;
            check({tag, ".gate_open"}, 32'(gate_open), 1);
            check({tag, ".alarm_rel"}, 32'(alarm), 0);
            model_clear;
            check_tallies({tag, ".released"});
            tick;
            check({tag, ".gate_pulse_end"}, 32'(gate_open), 0);
            check({tag, ".ready_after"}, 32'(scan_ready), 1);
        end else begin
            check({tag, ".ready_alarm"}, 32'(scan_ready), 0);
            check({tag, ".alarm_early"}, 32'(alarm), 0);
            tick;
            check({tag, ".alarm"}, 32'(alarm), 1);
            check({tag, ".gate_alarm"}, 32'(gate_open), 0);
            check_tallies({tag, ".frozen"});
            m_alarmed = 1;
        end
    endtask

    // While alarmed: scans and exit_req are ignored.
    task automatic poke_alarm(input logic [3:0] code, input string tag);
        scan_valid = 1'b1;
        scan_code  = code;
        exit_req   = 1'b1;
        tick;
        scan_valid = 1'b0;
        exit_req   = 1'b0;
        check({tag, ".alarm_hold"}, 32'(alarm), 1);
        check({tag, ".ready_hold"}, 32'(scan_ready), 0);
        check({tag, ".code_err"}, 32'(code_err), 0);
        check({tag, ".gate"}, 32'(gate_open), 0);
        check_tallies(tag);
    endtask

    task automatic ack(input string tag);
        alarm_ack = 1'b1;
        tick;
        alarm_ack = 1'b0;
        model_clear;
        check({tag, ".alarm_fall"}, 32'(alarm), 0);
        check({tag, ".ready"}, 32'(scan_ready), 1);
        check_tallies(tag);
    endtask

    initial begin
        logic [3:0] c;
        int n;
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 4'h0;
        exit_req   = 1'b0;
        alarm_ack  = 1'b0;
        m_disp     = 4'h0;
        model_clear;
        tick;
        tick;
        reset = 1'b0;

        check("rst.scan_ready", 32'(scan_ready), 1);
        check("rst.gate_open", 32'(gate_open), 0);
        check("rst.alarm", 32'(alarm), 0);
        check("rst.code_err", 32'(code_err), 0);
        check_tallies("rst");

        step(0, 4'h0, 1, "idle_exit");

        step(1, 4'b1101, 0, "sale1");
        step(1, 4'b0011, 1, "sale2_exit");

        step(1, 4'b0100, 0, "theft");
        step(0, 4'h0, 1, "theft_exit");
        poke_alarm(4'b0100, "alarm_scan");
        ack("ack1");

        step(1, 4'b0010, 0, "bad2");
        step(1, 4'b1111, 0, "bad7");
        step(0, 4'h0, 0, "bad_clear");

        for (int i = 0; i < 17; i++) step(1, 4'b0001, 0, "sat01");
        step(0, 4'h0, 1, "sat01_exit");
        for (int i = 0; i < 17; i++) step(1, 4'b0000, 0, "sat00");
        step(0, 4'h0, 1, "sat00_exit");

        // Asynchronous reset in the middle of an alarm.
        #2 reset = 1'b1;
        #1;
        model_clear;
        m_disp = 4'h0;
        check("midrst.alarm", 32'(alarm), 0);
        check("midrst.scan_ready", 32'(scan_ready), 1);
        check("midrst.gate_open", 32'(gate_open), 0);
        check_tallies("midrst");
        tick;
        reset = 1'b0;

        step(1, 4'b1101, 0, "same_pre");
        step(1, 4'b0000, 1, "same_cycle");
        ack("ack2");
        step(1, 4'b0100, 1, "idle_same_cycle");
        ack("ack3");

        step(1, 4'b1011, 0, "stray_pre");
        alarm_ack = 1'b1;
        tick;
        alarm_ack = 1'b0;
        check("stray_ack.alarm", 32'(alarm), 0);
        check_tallies("stray_ack");
        step(0, 4'h0, 1, "stray_exit");

        for (int s = 0; s < 25; s++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                c = 4'($urandom);
                step($urandom_range(0, 3) != 0, c, 0, "rnd_scan");
            end
            c = 4'($urandom);
            step($urandom_range(0, 1) == 1, c, 1, "rnd_exit");
            if (m_alarmed) begin
                if ($urandom_range(0, 1) == 1) poke_alarm(4'($urandom), "rnd_poke");
                ack("rnd_ack");
            end
        end

`ifdef UPC_SESSION_TIMEOUT_EN
        step(1, 4'b0100, 0, "to_scan");
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick;
            check("to_wait.gate", 32'(gate_open), 0);
            check("to_wait.items", 32'(item_cnt), 1);
        end
        tick;
        model_clear;
        check("to_done.gate", 32'(gate_open), 0);
        check("to_done.alarm", 32'(alarm), 0);
        check_tallies("to_done");
        tick;
        check("to_after.gate", 32'(gate_open), 0);
        check("to_after.alarm", 32'(alarm), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
